// File: rtl/kv_ledger_cuckoo.sv
`default_nettype none
// ============================================================================
// Module : kv_ledger_cuckoo
// Two-way cuckoo-hashed account ledger: lookup/insert/credit-debit/delete.
// Rev    : 1.0  initial release
// ============================================================================
module kv_ledger_cuckoo #(
    parameter int KEY_WIDTH       = 32,
    parameter int VALUE_WIDTH     = 32,
    parameter int TABLE_ADDR_BITS = 4,
    parameter int MAX_KICKS       = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [1:0]                 op_i,
    input  logic [KEY_WIDTH-1:0]       key_i,
    input  logic [VALUE_WIDTH-1:0]     transact_value_i,
    input  logic                       transact_kind_i,
    output logic                       rsp_valid_o,
    output logic [2:0]                 rsp_status_o,
    output logic [VALUE_WIDTH-1:0]     rsp_value_o,
    output logic [TABLE_ADDR_BITS:0]   rsp_value_addr_o
);
    localparam int A      = TABLE_ADDR_BITS;
    localparam int SLOTS  = 1 << A;
    localparam int VWORDS = 1 << (A + 1);
    localparam int KW     = (MAX_KICKS > 0) ? $clog2(MAX_KICKS + 1) : 1;
    localparam int PD     = 1 << KW;
    localparam logic [KW-1:0] KMAX = KW'(MAX_KICKS);

    localparam logic [1:0] OP_INSERT = 2'd1, OP_TRANSACT = 2'd2, OP_DELETE = 2'd3;
    localparam logic [2:0] ST_OK = 3'd0, ST_NOT_FOUND = 3'd1, ST_EXISTS = 3'd2,
                           ST_FULL = 3'd3, ST_INSUFF = 3'd4, ST_OVERFLOW = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_PROBE, S_PLACE, S_KICK, S_ROLLBACK, S_UPDATE, S_RESP
    } state_t;

    state_t state_q, state_d;
    logic   init_q;
    logic [1:0]             op_q, op_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [VALUE_WIDTH-1:0] val_q, val_d;
    logic                   kind_q, kind_d;
    logic [SLOTS-1:0]       t1_valid_q, t1_valid_d, t2_valid_q, t2_valid_d;
    logic [KEY_WIDTH-1:0]   t1_key_q [SLOTS], t1_key_d [SLOTS];
    logic [KEY_WIDTH-1:0]   t2_key_q [SLOTS], t2_key_d [SLOTS];
    logic [A:0]             t1_vaddr_q [SLOTS], t1_vaddr_d [SLOTS];
    logic [A:0]             t2_vaddr_q [SLOTS], t2_vaddr_d [SLOTS];
    logic [VALUE_WIDTH-1:0] vmem_q [VWORDS], vmem_d [VWORDS];
    logic [VWORDS-1:0]      free_q, free_d;
    logic [KEY_WIDTH-1:0]   cur_key_q, cur_key_d;
    logic [A:0]             cur_vaddr_q, cur_vaddr_d, vaddr_q, vaddr_d;
    logic [KW-1:0]          kick_q, kick_d;
    logic [A-1:0]           path_q [PD], path_d [PD];
    logic [2:0]             res_status_q, res_status_d, rsp_status_q, rsp_status_d;
    logic [VALUE_WIDTH-1:0] res_value_q, res_value_d, rsp_value_q, rsp_value_d;
    logic [A:0]             res_addr_q, res_addr_d, rsp_addr_q, rsp_addr_d;
    logic                   rsp_valid_q, rsp_valid_d;

    function automatic logic [A-1:0] f_h1(input logic [A-1:0] k);
        return k;
    endfunction
    function automatic logic [A-1:0] f_h2(input logic [2*A-1:0] k);
        return k[2*A-1:A] ^ k[A-1:0];
    endfunction

    logic [A-1:0]           w_h1, w_h2, w_cur_idx, w_tgt_idx, w_rb_idx;
    logic                   w_hit1, w_hit2, w_hit, w_side, w_tgt_free, w_rb_side, w_any_free, w_commit;
    logic [A:0]             w_hit_vaddr, w_free_idx, w_disp_vaddr;
    logic [KEY_WIDTH-1:0]   w_disp_key;
    logic [KW-1:0]          w_kick_nxt, w_rb_j;
    logic [VALUE_WIDTH-1:0] w_bal;
    logic [VALUE_WIDTH:0]   w_sum;

    assign w_h1        = f_h1(key_q[A-1:0]);
    assign w_h2        = f_h2(key_q[2*A-1:0]);
    assign w_hit1      = t1_valid_q[w_h1] && (t1_key_q[w_h1] == key_q);
    assign w_hit2      = t2_valid_q[w_h2] && (t2_key_q[w_h2] == key_q);
    assign w_hit       = w_hit1 || w_hit2;
    assign w_hit_vaddr = w_hit1 ? t1_vaddr_q[w_h1] : t2_vaddr_q[w_h2];

    // Kick sides alternate T1, T2, T1 ... so the side is the kick count's LSB.
    assign w_side       = kick_q[0];
    assign w_cur_idx    = w_side ? f_h2(cur_key_q[2*A-1:0]) : f_h1(cur_key_q[A-1:0]);
    assign w_disp_key   = w_side ? t2_key_q[w_cur_idx] : t1_key_q[w_cur_idx];
    assign w_disp_vaddr = w_side ? t2_vaddr_q[w_cur_idx] : t1_vaddr_q[w_cur_idx];
    assign w_tgt_idx    = w_side ? f_h1(w_disp_key[A-1:0]) : f_h2(w_disp_key[2*A-1:0]);
    assign w_tgt_free   = w_side ? !t1_valid_q[w_tgt_idx] : !t2_valid_q[w_tgt_idx];
    assign w_kick_nxt   = kick_q + 1'b1;
    assign w_rb_j       = kick_q - 1'b1;
    assign w_rb_side    = w_rb_j[0];
    assign w_rb_idx     = path_q[w_rb_j];
    assign w_bal        = vmem_q[vaddr_q];
    assign w_sum        = {1'b0, w_bal} + {1'b0, val_q};

    always_comb begin
        w_free_idx = '0;
        w_any_free = 1'b0;
        for (int i = VWORDS - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                w_free_idx = (A + 1)'(i);
                w_any_free = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;   op_d = op_q;   key_d = key_q;   val_d = val_q;   kind_d = kind_q;
        t1_valid_d = t1_valid_q;   t1_key_d = t1_key_q;   t1_vaddr_d = t1_vaddr_q;
        t2_valid_d = t2_valid_q;   t2_key_d = t2_key_q;   t2_vaddr_d = t2_vaddr_q;
        vmem_d = vmem_q;   free_d = free_q;   path_d = path_q;   kick_d = kick_q;
        cur_key_d = cur_key_q;   cur_vaddr_d = cur_vaddr_q;   vaddr_d = vaddr_q;
        res_status_d = res_status_q;   res_value_d = res_value_q;   res_addr_d = res_addr_q;
        rsp_valid_d = 1'b0;   rsp_status_d = rsp_status_q;
        rsp_value_d = rsp_value_q;   rsp_addr_d = rsp_addr_q;
        w_commit = 1'b0;
        case (state_q)
            S_IDLE: if (req_valid_i && init_q) begin
                op_d = op_i;  key_d = key_i;  val_d = transact_value_i;  kind_d = transact_kind_i;
                state_d = S_PROBE;
            end
            S_PROBE: begin
                vaddr_d      = w_hit_vaddr;
                res_status_d = w_hit ? ST_OK : ST_NOT_FOUND;
                res_value_d  = w_hit ? vmem_q[w_hit_vaddr] : '0;
                res_addr_d   = w_hit ? w_hit_vaddr : '0;
                state_d      = S_RESP;
                if (op_q == OP_TRANSACT && w_hit) begin
                    state_d = S_UPDATE;
                end else if (op_q == OP_DELETE && w_hit) begin
                    if (w_hit1) t1_valid_d[w_h1] = 1'b0;
                    else        t2_valid_d[w_h2] = 1'b0;
                    free_d[w_hit_vaddr] = 1'b1;
                end else if (op_q == OP_INSERT) begin
                    if (w_hit) begin
                        res_status_d = ST_EXISTS;
                    end else if (!w_any_free ||
                                 (MAX_KICKS == 0 && t1_valid_q[w_h1] && t2_valid_q[w_h2])) begin
                        res_status_d = ST_FULL;
                    end else begin
                        vaddr_d     = w_free_idx;
                        cur_key_d   = key_q;
                        cur_vaddr_d = w_free_idx;
                        kick_d      = '0;
                        state_d     = S_PLACE;
                    end
                end
            end
            S_PLACE: begin
                if (!t1_valid_q[w_h1]) begin
                    t1_valid_d[w_h1] = 1'b1;  t1_key_d[w_h1] = key_q;  t1_vaddr_d[w_h1] = vaddr_q;
                    w_commit = 1'b1;
                end else if (!t2_valid_q[w_h2]) begin
                    t2_valid_d[w_h2] = 1'b1;  t2_key_d[w_h2] = key_q;  t2_vaddr_d[w_h2] = vaddr_q;
                    w_commit = 1'b1;
                end else begin
                    state_d = S_KICK;
                end
            end
            S_KICK: begin
                if (w_side) begin
                    t2_key_d[w_cur_idx] = cur_key_q;  t2_vaddr_d[w_cur_idx] = cur_vaddr_q;
                end else begin
                    t1_key_d[w_cur_idx] = cur_key_q;  t1_vaddr_d[w_cur_idx] = cur_vaddr_q;
                end
                if (w_tgt_free) begin
                    if (w_side) begin
                        t1_valid_d[w_tgt_idx] = 1'b1;  t1_key_d[w_tgt_idx] = w_disp_key;
                        t1_vaddr_d[w_tgt_idx] = w_disp_vaddr;
                    end else begin
                        t2_valid_d[w_tgt_idx] = 1'b1;  t2_key_d[w_tgt_idx] = w_disp_key;
                        t2_vaddr_d[w_tgt_idx] = w_disp_vaddr;
                    end
                    w_commit = 1'b1;
                end else begin
                    cur_key_d      = w_disp_key;
                    cur_vaddr_d    = w_disp_vaddr;
                    path_d[kick_q] = w_cur_idx;
                    kick_d         = w_kick_nxt;
                    if (w_kick_nxt == KMAX) state_d = S_ROLLBACK;
                end
            end
            S_ROLLBACK: begin
                // Undo the swaps newest-first; each swap is its own inverse.
                if (w_rb_side) begin
                    t2_key_d[w_rb_idx] = cur_key_q;  t2_vaddr_d[w_rb_idx] = cur_vaddr_q;
                    cur_key_d = t2_key_q[w_rb_idx];  cur_vaddr_d = t2_vaddr_q[w_rb_idx];
                end else begin
                    t1_key_d[w_rb_idx] = cur_key_q;  t1_vaddr_d[w_rb_idx] = cur_vaddr_q;
                    cur_key_d = t1_key_q[w_rb_idx];  cur_vaddr_d = t1_vaddr_q[w_rb_idx];
                end
                kick_d = w_rb_j;
                if (w_rb_j == '0) begin
                    res_status_d = ST_FULL;  res_value_d = '0;  res_addr_d = '0;
                    state_d = S_RESP;
                end
            end
            S_UPDATE: begin
                res_value_d = w_bal;
                if (!kind_q && w_sum[VALUE_WIDTH]) begin
                    res_status_d = ST_OVERFLOW;
                end else if (kind_q && (val_q > w_bal)) begin
                    res_status_d = ST_INSUFF;
                end else begin
                    res_status_d    = ST_OK;
                    res_value_d     = kind_q ? (w_bal - val_q) : w_sum[VALUE_WIDTH-1:0];
                    vmem_d[vaddr_q] = res_value_d;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid_d  = 1'b1;
                rsp_status_d = res_status_q;  rsp_value_d = res_value_q;  rsp_addr_d = res_addr_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (w_commit) begin
            vmem_d[vaddr_q] = val_q;
            free_d[vaddr_q] = 1'b0;
            res_status_d = ST_OK;  res_value_d = val_q;  res_addr_d = vaddr_q;
            state_d = S_RESP;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;   init_q <= 1'b0;
            t1_valid_q <= '0;    t2_valid_q <= '0;   free_q <= '1;
            rsp_valid_q <= 1'b0; rsp_status_q <= '0; rsp_value_q <= '0; rsp_addr_q <= '0;
        end else begin
            state_q <= state_d;  init_q <= 1'b1;
            t1_valid_q <= t1_valid_d;  t2_valid_q <= t2_valid_d;  free_q <= free_d;
            rsp_valid_q <= rsp_valid_d;  rsp_status_q <= rsp_status_d;
            rsp_value_q <= rsp_value_d;  rsp_addr_q <= rsp_addr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        op_q <= op_d;  key_q <= key_d;  val_q <= val_d;  kind_q <= kind_d;
        t1_key_q <= t1_key_d;  t1_vaddr_q <= t1_vaddr_d;
        t2_key_q <= t2_key_d;  t2_vaddr_q <= t2_vaddr_d;
        vmem_q <= vmem_d;  path_q <= path_d;  kick_q <= kick_d;
        cur_key_q <= cur_key_d;  cur_vaddr_q <= cur_vaddr_d;  vaddr_q <= vaddr_d;
        res_status_q <= res_status_d;  res_value_q <= res_value_d;  res_addr_q <= res_addr_d;
    end

    assign req_ready_o      = (state_q == S_IDLE) && init_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_status_o     = rsp_status_q;
    assign rsp_value_o      = rsp_value_q;
    assign rsp_value_addr_o = rsp_addr_q;
endmodule
`default_nettype wire

// File: tb/tb_kv_ledger_cuckoo.sv
`default_nettype none
// ============================================================================
// Module : tb_kv_ledger_cuckoo
// Scoreboard bench: DUT 0 allows 4 kicks, DUT 1 allows none.
// Rev    : 1.0  initial release
// ============================================================================
module tb_kv_ledger_cuckoo;
    localparam logic [1:0] LOOKUP = 2'd0, INSERT = 2'd1, TRANSACT = 2'd2, DELETE = 2'd3;
    localparam logic [2:0] OK = 3'd0, NF = 3'd1, EXISTS = 3'd2, FULL = 3'd3,
                           INSUFF = 3'd4, OVF = 3'd5;

    typedef struct {
        logic [2:0]  st;
        logic [31:0] val;
        logic [4:0]  addr;
        int          due;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0][1:0]  op;
    logic [1:0][31:0] key, tval;
    logic [1:0]       kind;
    wire  [1:0]       req_ready, rsp_valid;
    wire  [1:0][2:0]  rsp_status;
    wire  [1:0][31:0] rsp_value;
    wire  [1:0][4:0]  rsp_addr;

    int   tests = 0, fails = 0;
    exp_t q0[$], q1[$];

    kv_ledger_cuckoo #(.KEY_WIDTH(32), .VALUE_WIDTH(32), .TABLE_ADDR_BITS(4), .MAX_KICKS(4)) dut_k4 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .op_i(op[0]), .key_i(key[0]), .transact_value_i(tval[0]), .transact_kind_i(kind[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_status_o(rsp_status[0]), .rsp_value_o(rsp_value[0]),
        .rsp_value_addr_o(rsp_addr[0]));

    kv_ledger_cuckoo #(.KEY_WIDTH(32), .VALUE_WIDTH(32), .TABLE_ADDR_BITS(4), .MAX_KICKS(0)) dut_k0 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .op_i(op[1]), .key_i(key[1]), .transact_value_i(tval[1]), .transact_kind_i(kind[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_status_o(rsp_status[1]), .rsp_value_o(rsp_value[1]),
        .rsp_value_addr_o(rsp_addr[1]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic check_rsp(input int d);
        exp_t e;
        if (qsize(d) == 0) begin
            chk($sformatf("unexpected_rsp_dut%0d", d), 64'(rsp_valid[d]), 64'(0));
        end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk({e.tag, " status"}, 64'(rsp_status[d]), 64'(e.st));
            chk({e.tag, " value"},  64'(rsp_value[d]),  64'(e.val));
            chk({e.tag, " addr"},   64'(rsp_addr[d]),   64'(e.addr));
            chk({e.tag, " cycle"},  64'(cyc),           64'(e.due));
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++)
            if (rsp_valid[d] === 1'b1) check_rsp(d);
    end

    task automatic send(input int d, input logic [1:0] o, input logic [31:0] k,
                        input logic [31:0] v, input logic kd, output int acc);
        int t = 0;
        @(negedge clk);
        op[d] = o;  key[d] = k;  tval[d] = v;  kind[d] = kd;  req_valid[d] = 1'b1;
        while (req_ready[d] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 64'(req_ready[d]), 64'(1));
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid[d] = 1'b0;
        op[d] = 2'($urandom_range(3));  key[d] = $urandom;  tval[d] = $urandom;
        kind[d] = 1'($urandom_range(1));
        chk($sformatf("busy_ready_dut%0d", d), 64'(req_ready[d]), 64'(0));
    endtask

    task automatic do_req(input int d, input logic [1:0] o, input logic [31:0] k,
                          input logic [31:0] v, input logic kd, input logic [2:0] st,
                          input logic [31:0] ev, input logic [4:0] ea, input int lat,
                          input string tag);
        int   acc;
        int   t = 0;
        exp_t e;
        send(d, o, k, v, kd, acc);
        e.st = st;  e.val = ev;  e.addr = ea;  e.due = acc + lat;  e.tag = tag;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        while (qsize(d) != 0 && t < 40) begin
            @(posedge clk);
            t++;
        end
        if (qsize(d) != 0) begin
            chk({tag, " timeout"}, 64'(qsize(d)), 64'(0));
            if (d == 0) q0.delete();
            else        q1.delete();
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s ready d%0d", tag, d),      64'(req_ready[d]),  64'(0));
            chk($sformatf("%s rsp_valid d%0d", tag, d),  64'(rsp_valid[d]),  64'(0));
            chk($sformatf("%s rsp_status d%0d", tag, d), 64'(rsp_status[d]), 64'(0));
            chk($sformatf("%s rsp_value d%0d", tag, d),  64'(rsp_value[d]),  64'(0));
            chk($sformatf("%s rsp_addr d%0d", tag, d),   64'(rsp_addr[d]),   64'(0));
        end
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, " ready_at_release d0"}, 64'(req_ready[0]), 64'(0));
        chk({tag, " ready_at_release d1"}, 64'(req_ready[1]), 64'(0));
        @(posedge clk);
        #1;
        chk({tag, " ready_after_edge d0"}, 64'(req_ready[0]), 64'(1));
        chk({tag, " ready_after_edge d1"}, 64'(req_ready[1]), 64'(1));
    endtask

    initial begin
        int acc;
        rst_n = 1'b0;  req_valid = '0;  op = '0;  key = '0;  tval = '0;  kind = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        release_reset("por");

        // Basic insert / lookup / transactions on key 249
        do_req(0, INSERT,   32'd249, 32'd100, 1'b0, OK, 32'd100, 5'd0, 3, "ins249");
        do_req(0, LOOKUP,   32'd249, 32'd0,   1'b0, OK, 32'd100, 5'd0, 2, "lkp249");
        repeat (3) @(negedge clk);
        chk("rsp_hold value", 64'(rsp_value[0]), 64'(100));
        do_req(0, INSERT,   32'd249, 32'd7,   1'b0, EXISTS, 32'd100, 5'd0, 2, "ins249_dup");
        do_req(0, TRANSACT, 32'd249, 32'd150, 1'b1, INSUFF, 32'd100, 5'd0, 3, "debit150");
        do_req(0, TRANSACT, 32'd249, 32'd100, 1'b1, OK, 32'd0, 5'd0, 3, "debit100");
        do_req(0, TRANSACT, 32'd249, 32'hFFFF_FFF0, 1'b0, OK, 32'hFFFF_FFF0, 5'd0, 3, "credit_big");
        do_req(0, TRANSACT, 32'd249, 32'h20,  1'b0, OVF, 32'hFFFF_FFF0, 5'd0, 3, "credit_ovf");
        do_req(0, TRANSACT, 32'h55,  32'd1,   1'b0, NF, 32'd0, 5'd0, 2, "trans_miss");
        do_req(0, DELETE,   32'd249, 32'd0,   1'b0, OK, 32'hFFFF_FFF0, 5'd0, 2, "del249");
        do_req(0, LOOKUP,   32'd249, 32'd0,   1'b0, NF, 32'd0, 5'd0, 2, "lkp249_gone");
        do_req(0, DELETE,   32'd249, 32'd0,   1'b0, NF, 32'd0, 5'd0, 2, "del249_again");

        // Single-kick cuckoo insert
        do_req(0, INSERT, 32'h09,  32'd11, 1'b0, OK, 32'd11, 5'd0, 3, "k4_ins09");
        do_req(0, INSERT, 32'h19,  32'd22, 1'b0, OK, 32'd22, 5'd1, 3, "k4_ins19");
        do_req(0, INSERT, 32'h119, 32'd33, 1'b0, OK, 32'd33, 5'd2, 4, "k4_ins119");
        do_req(0, LOOKUP, 32'h119, 32'd0,  1'b0, OK, 32'd33, 5'd2, 2, "k4_lkp119");
        do_req(0, LOOKUP, 32'h09,  32'd0,  1'b0, OK, 32'd11, 5'd0, 2, "k4_lkp09");
        do_req(0, LOOKUP, 32'h19,  32'd0,  1'b0, OK, 32'd22, 5'd1, 2, "k4_lkp19");

        // Delete and value-slot reuse
        do_req(0, DELETE, 32'h09, 32'd0,  1'b0, OK, 32'd11, 5'd0, 2, "k4_del09");
        do_req(0, LOOKUP, 32'h09, 32'd0,  1'b0, NF, 32'd0,  5'd0, 2, "k4_lkp09_gone");
        do_req(0, INSERT, 32'h77, 32'd77, 1'b0, OK, 32'd77, 5'd0, 3, "k4_ins77");
        do_req(0, LOOKUP, 32'h77, 32'd0,  1'b0, OK, 32'd77, 5'd0, 2, "k4_lkp77");

        // Four kicks then full rollback: 0x023/0x123/0x223 share both slots
        do_req(0, INSERT, 32'h023, 32'h23,  1'b0, OK, 32'h23,  5'd3, 3, "k4_ins023");
        do_req(0, INSERT, 32'h123, 32'h123, 1'b0, OK, 32'h123, 5'd4, 3, "k4_ins123");
        do_req(0, INSERT, 32'h223, 32'h223, 1'b0, FULL, 32'd0, 5'd0, 11, "k4_ins223_full");
        do_req(0, LOOKUP, 32'h223, 32'd0,   1'b0, NF, 32'd0,   5'd0, 2, "k4_lkp223");
        do_req(0, LOOKUP, 32'h023, 32'd0,   1'b0, OK, 32'h23,  5'd3, 2, "k4_lkp023");
        do_req(0, LOOKUP, 32'h123, 32'd0,   1'b0, OK, 32'h123, 5'd4, 2, "k4_lkp123");
        do_req(0, LOOKUP, 32'h119, 32'd0,   1'b0, OK, 32'd33,  5'd2, 2, "k4_lkp119_after");
        do_req(0, INSERT, 32'h045, 32'h45,  1'b0, OK, 32'h45,  5'd5, 3, "k4_ins045");

        // Eviction disabled
        do_req(1, INSERT, 32'h09,  32'd11, 1'b0, OK, 32'd11, 5'd0, 3, "k0_ins09");
        do_req(1, INSERT, 32'h19,  32'd22, 1'b0, OK, 32'd22, 5'd1, 3, "k0_ins19");
        do_req(1, INSERT, 32'h119, 32'd33, 1'b0, FULL, 32'd0, 5'd0, 2, "k0_ins119_full");
        do_req(1, LOOKUP, 32'h119, 32'd0,  1'b0, NF, 32'd0,  5'd0, 2, "k0_lkp119");
        do_req(1, LOOKUP, 32'h09,  32'd0,  1'b0, OK, 32'd11, 5'd0, 2, "k0_lkp09");
        do_req(1, LOOKUP, 32'h19,  32'd0,  1'b0, OK, 32'd22, 5'd1, 2, "k0_lkp19");
        do_req(1, INSERT, 32'h05,  32'd55, 1'b0, OK, 32'd55, 5'd2, 3, "k0_ins05");

        // Reset asserted while DUT 0 is in a kick cycle
        send(0, INSERT, 32'h223, 32'd5, 1'b0, acc);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("midop_reset");
        release_reset("midop");
        repeat (15) @(negedge clk);
        do_req(0, LOOKUP, 32'h023, 32'd0, 1'b0, NF, 32'd0, 5'd0, 2, "rst_lkp023");
        do_req(0, LOOKUP, 32'h77,  32'd0, 1'b0, NF, 32'd0, 5'd0, 2, "rst_lkp77");
        do_req(1, LOOKUP, 32'h09,  32'd0, 1'b0, NF, 32'd0, 5'd0, 2, "rst_lkp09_k0");
        do_req(0, INSERT, 32'h023, 32'd9, 1'b0, OK, 32'd9, 5'd0, 3, "rst_ins023");

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
